// File: rtl/jogador_automatico_pkg.sv
// Shared definitions for the automatic memory-game player.
// State encoding, default sizing constants and small helpers used by the
// player, the game top level and system benches.
package jogador_automatico_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OBSERVA  = 2'd1,
    JOGA_ON  = 2'd2,
    JOGA_OFF = 2'd3
  } estado_t;

  localparam int unsigned DEPTH_PADRAO = 16;
  localparam int unsigned QUIET_PADRAO = 100;
  localparam int unsigned HOLD_PADRAO  = 8;
  localparam int unsigned GAP_PADRAO   = 8;

  function automatic int unsigned maxOf3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Deliberately wrong press: one-hot value rotated left by one position.
  function automatic logic [3:0] rotEsq(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/jogador_automatico_buffer.sv
// buffer_sequencia: DEPTH x 4 register file holding the observed sequence.
// Ports:
//   clock, reset      - rising-edge clock, asynchronous active-low clear
//   escreve           - write enable
//   endEscrita        - write address
//   dadoEscrita       - write data (LED value)
//   endLeitura        - read address (asynchronous read)
//   dadoLido          - read data
module buffer_sequencia
  import jogador_automatico_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       escreve,
  input  logic [3:0] endEscrita,
  input  logic [3:0] dadoEscrita,
  input  logic [3:0] endLeitura,
  output logic [3:0] dadoLido
);

  logic [3:0] mem [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (escreve) begin
      mem[endEscrita] <= dadoEscrita;
    end
  end

  assign dadoLido = mem[endLeitura];

endmodule

// File: rtl/jogador_automatico.sv
// jogador_automatico: automatic player for the memory game.
// Watches the LED bus while the game shows a sequence, stores each new
// display, and after a long enough silence replays the stored values on the
// switch bus as timed presses. Optionally corrupts one press.
// Ports:
//   clock, reset    - rising-edge clock, asynchronous active-low reset
//   habilita        - level enable, low forces IDLE
//   leds            - game LED bus (one-hot while lit, 0 while off)
//   erro_en         - enable wrong-press injection
//   erro_idx        - playback index that receives the wrong press
//   chaves          - registered key-press output
//   jogando         - high while replaying (JOGA_ON / JOGA_OFF)
//   pronto          - one-cycle pulse when a round's playback completes
//   overflow        - sticky, capture attempted with the buffer full
//   db_estado       - current state encoding
//   db_contagem     - number of stored values
module jogador_automatico
  import jogador_automatico_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_PADRAO,
  parameter int unsigned QUIET = QUIET_PADRAO,
  parameter int unsigned HOLD  = HOLD_PADRAO,
  parameter int unsigned GAP   = GAP_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [3:0] leds,
  input  logic       erro_en,
  input  logic [3:0] erro_idx,
  output logic [3:0] chaves,
  output logic       jogando,
  output logic       pronto,
  output logic       overflow,
  output logic [3:0] db_estado,
  output logic [4:0] db_contagem
);

  localparam int unsigned TW = $clog2(maxOf3(QUIET, HOLD, GAP) + 1);
  localparam logic [TW-1:0] QUIET_FIM = TW'(QUIET - 1);
  localparam logic [TW-1:0] HOLD_FIM  = TW'(HOLD - 1);
  localparam logic [TW-1:0] GAP_FIM   = TW'(GAP - 1);
  localparam logic [TW-1:0] QUIET_SAT = TW'(QUIET);
  localparam logic [TW-1:0] HOLD_SAT  = TW'(HOLD);
  localparam logic [TW-1:0] GAP_SAT   = TW'(GAP);
  localparam logic [4:0]    CHEIO     = 5'(DEPTH);

  estado_t       estado, estadoProx;
  logic [3:0]    ledsPrev;
  logic [4:0]    contagem, contagemProx;
  logic [3:0]    indice, indiceProx;
  logic [TW-1:0] silencio, silencioProx;
  logic [TW-1:0] tempo, tempoProx;
  logic          prontoProx;
  logic          overflowProx;
  logic [3:0]    chavesProx;
  logic          escreve;
  logic [3:0]    endEscrita;
  logic [3:0]    dadoLido;
  logic          novaExibicao;

  assign novaExibicao = (leds != 4'd0) && (leds != ledsPrev);

  buffer_sequencia #(
    .DEPTH(DEPTH)
  ) uBuffer (
    .clock      (clock),
    .reset      (reset),
    .escreve    (escreve),
    .endEscrita (endEscrita),
    .dadoEscrita(leds),
    .endLeitura (indiceProx),
    .dadoLido   (dadoLido)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= IDLE;
      ledsPrev <= '0;
      contagem <= '0;
      indice   <= '0;
      silencio <= '0;
      tempo    <= '0;
      pronto   <= 1'b0;
      overflow <= 1'b0;
      chaves   <= '0;
    end else begin
      estado   <= estadoProx;
      ledsPrev <= leds;
      contagem <= contagemProx;
      indice   <= indiceProx;
      silencio <= silencioProx;
      tempo    <= tempoProx;
      pronto   <= prontoProx;
      overflow <= overflowProx;
      chaves   <= chavesProx;
    end
  end

  always_comb begin
    estadoProx   = estado;
    contagemProx = contagem;
    indiceProx   = indice;
    silencioProx = silencio;
    tempoProx    = tempo;
    prontoProx   = 1'b0;
    overflowProx = overflow;
    escreve      = 1'b0;
    endEscrita   = contagem[3:0];

    if (!habilita) begin
      // Dropping the enable beats any capture or phase end on the same edge.
      estadoProx   = IDLE;
      contagemProx = '0;
      indiceProx   = '0;
      silencioProx = '0;
      tempoProx    = '0;
    end else begin
      case (estado)
        IDLE: begin
          contagemProx = '0;
          indiceProx   = '0;
          silencioProx = '0;
          tempoProx    = '0;
          if (novaExibicao) begin
            escreve      = 1'b1;
            endEscrita   = '0;
            contagemProx = 5'd1;
            overflowProx = 1'b0;
            estadoProx   = OBSERVA;
          end
        end

        OBSERVA: begin
          if (novaExibicao) begin
            if (contagem == CHEIO) begin
              overflowProx = 1'b1;
            end else begin
              escreve      = 1'b1;
              contagemProx = contagem + 5'd1;
            end
          end
          // The edge that would bring the silence count to QUIET starts playback,
          // so the first press lands exactly QUIET cycles after silence began.
          if (leds != 4'd0) begin
            silencioProx = '0;
          end else if (silencio == QUIET_FIM) begin
            silencioProx = '0;
            indiceProx   = '0;
            tempoProx    = '0;
            estadoProx   = JOGA_ON;
          end else if (silencio != QUIET_SAT) begin
            silencioProx = silencio + 1'b1;
          end
        end

        JOGA_ON: begin
          if (tempo == HOLD_FIM) begin
            tempoProx  = '0;
            estadoProx = JOGA_OFF;
          end else if (tempo != HOLD_SAT) begin
            tempoProx = tempo + 1'b1;
          end
        end

        JOGA_OFF: begin
          if (tempo == GAP_FIM) begin
            tempoProx = '0;
            if (({1'b0, indice} + 5'd1) == contagem) begin
              prontoProx   = 1'b1;
              contagemProx = '0;
              indiceProx   = '0;
              estadoProx   = IDLE;
            end else begin
              indiceProx = indice + 4'd1;
              estadoProx = JOGA_ON;
            end
          end else if (tempo != GAP_SAT) begin
            tempoProx = tempo + 1'b1;
          end
        end

        default: estadoProx = IDLE;
      endcase
    end
  end

  // The output register is loaded from the next state and next index so the
  // press value is on chaves during the very first JOGA_ON cycle.
  always_comb begin
    chavesProx = '0;
    if (estadoProx == JOGA_ON) begin
      if (erro_en && (indiceProx == erro_idx)) begin
        chavesProx = rotEsq(dadoLido);
      end else begin
        chavesProx = dadoLido;
      end
    end
  end

  assign jogando     = (estado == JOGA_ON) || (estado == JOGA_OFF);
  assign db_estado   = {2'b00, estado};
  assign db_contagem = contagem;

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: per-scenario stimulus tables, a timeline model
// that derives every cycle's expected outputs from the observed LED sequence,
// and hand-computed pinned values at key cycles.
module tb_jogador_automatico;

  localparam int unsigned MAXC = 600;
  localparam int unsigned DEP  = 16;
  localparam int unsigned QT   = 100;
  localparam int unsigned HD   = 8;
  localparam int unsigned GP   = 8;

  typedef struct {
    int unsigned cyc;
    int unsigned fld;   // 0 chaves, 1 pronto, 2 overflow, 3 estado, 4 contagem
    int unsigned val;
  } pin_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       habilita = 1'b0;
  logic [3:0] leds = 4'd0;
  logic       erro_en = 1'b0;
  logic [3:0] erro_idx = 4'd0;
  logic [3:0] chaves;
  logic       jogando;
  logic       pronto;
  logic       overflow;
  logic [3:0] db_estado;
  logic [4:0] db_contagem;

  always #5 clock = ~clock;

  jogador_automatico #(
    .DEPTH(16),
    .QUIET(100),
    .HOLD (8),
    .GAP  (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .habilita   (habilita),
    .leds       (leds),
    .erro_en    (erro_en),
    .erro_idx   (erro_idx),
    .chaves     (chaves),
    .jogando    (jogando),
    .pronto     (pronto),
    .overflow   (overflow),
    .db_estado  (db_estado),
    .db_contagem(db_contagem)
  );

  logic [3:0]  ledsV  [MAXC];
  bit          habV   [MAXC];
  logic [3:0]  expCh  [MAXC];
  logic [3:0]  expEst [MAXC];
  logic [4:0]  expCnt [MAXC];
  bit          expJog [MAXC];
  bit          expPr  [MAXC];
  bit          expOv  [MAXC];
  int unsigned nCyc;
  int unsigned cyc;
  bit          checking;
  int unsigned nVec;
  int unsigned nMis;
  pin_t        pins[$];

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic clearStim(input int unsigned n);
    nCyc = n;
    for (int unsigned i = 0; i < MAXC; i++) begin
      ledsV[i] = 4'd0;
      habV[i]  = 1'b1;
    end
    pins.delete();
  endtask

  task automatic setLeds(input int unsigned a, input int unsigned b, input logic [3:0] v);
    for (int unsigned i = a; i <= b; i++) ledsV[i] = v;
  endtask

  task automatic setHab(input int unsigned a, input int unsigned b, input bit v);
    for (int unsigned i = a; i <= b; i++) habV[i] = v;
  endtask

  task automatic pin(input int unsigned c, input int unsigned f, input int unsigned v);
    pin_t p;
    p.cyc = c;
    p.fld = f;
    p.val = v;
    pins.push_back(p);
  endtask

  function automatic bit isNew(input int unsigned c);
    logic [3:0] prev;
    prev = (c == 0) ? 4'd0 : ledsV[c-1];
    return (ledsV[c] != 4'd0) && (ledsV[c] != prev);
  endfunction

  task automatic fill(input int unsigned q, input logic [3:0] est, input logic [3:0] ch,
                      input bit jog, input int unsigned cnt, input bit ov);
    expEst[q] = est;
    expCh[q]  = ch;
    expJog[q] = jog;
    expCnt[q] = 5'(cnt);
    expOv[q]  = ov;
    expPr[q]  = 1'b0;
  endtask

  // Timeline model: find the round start, collect displays until QUIET zeros,
  // then lay out HOLD/GAP windows per stored value; habilita low ends the round.
  task automatic buildExpected();
    int unsigned c, t, q, z, prontoAt;
    bit ovf, live, fim, temPronto;
    logic [3:0] vals[$];
    logic [3:0] v;
    c = 0; ovf = 1'b0; temPronto = 1'b0; prontoAt = 0;
    while (c < nCyc) begin
      fill(c, 4'd0, 4'd0, 1'b0, 0, ovf);
      expPr[c] = temPronto && (c == prontoAt);
      if (habV[c] && isNew(c)) begin
        vals.delete();
        vals.push_back(ledsV[c]);
        ovf = 1'b0; z = 0; live = 1'b1; fim = 1'b0; t = c;
        while (live && !fim) begin
          t++;
          if (t >= nCyc) begin
            live = 1'b0;
          end else begin
            fill(t, 4'd1, 4'd0, 1'b0, vals.size(), ovf);
            if (!habV[t]) begin
              live = 1'b0;
            end else begin
              if (isNew(t)) begin
                if (vals.size() < DEP) vals.push_back(ledsV[t]);
                else ovf = 1'b1;
              end
              z = (ledsV[t] == 4'd0) ? z + 1 : 0;
              if (z == QT) fim = 1'b1;
            end
          end
        end
        if (!live) begin
          c = t + 1;
          continue;
        end
        q = t + 1;
        for (int unsigned k = 0; k < vals.size() && live; k++) begin
          for (int unsigned j = 0; j < HD + GP && live; j++) begin
            if (q >= nCyc) begin
              live = 1'b0;
            end else begin
              v = vals[k];
              if (erro_en && (k == 32'(erro_idx))) v = {v[2:0], v[3]};
              if (j < HD) fill(q, 4'd2, v, 1'b1, vals.size(), ovf);
              else        fill(q, 4'd3, 4'd0, 1'b1, vals.size(), ovf);
              if (!habV[q]) live = 1'b0;
              q++;
            end
          end
        end
        if (live) begin
          temPronto = 1'b1;
          prontoAt  = q;
        end
        c = q;
        continue;
      end
      c++;
    end
  endtask

  always @(negedge clock) begin
    if (checking) begin
      chk("chaves",      32'(chaves),      32'(expCh[cyc]));
      chk("jogando",     32'(jogando),     32'(expJog[cyc]));
      chk("pronto",      32'(pronto),      32'(expPr[cyc]));
      chk("overflow",    32'(overflow),    32'(expOv[cyc]));
      chk("db_estado",   32'(db_estado),   32'(expEst[cyc]));
      chk("db_contagem", 32'(db_contagem), 32'(expCnt[cyc]));
      foreach (pins[i]) begin
        if (pins[i].cyc == cyc) begin
          case (pins[i].fld)
            0:       chk("pin_chaves",   32'(chaves),      pins[i].val);
            1:       chk("pin_pronto",   32'(pronto),      pins[i].val);
            2:       chk("pin_overflow", 32'(overflow),    pins[i].val);
            3:       chk("pin_estado",   32'(db_estado),   pins[i].val);
            default: chk("pin_contagem", 32'(db_contagem), pins[i].val);
          endcase
        end
      end
    end
  end

  task automatic doReset();
    reset    = 1'b0;
    leds     = 4'd0;
    habilita = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic runScenario();
    buildExpected();
    for (int unsigned c = 0; c < nCyc; c++) begin
      @(posedge clock);
      #1;
      cyc      = c;
      leds     = ledsV[c];
      habilita = habV[c];
      checking = 1'b1;
      @(negedge clock);
    end
    @(posedge clock);
    #1;
    checking = 1'b0;
  endtask

  initial begin
    #200000;
    nMis++;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] seq5 [5];
    nVec = 0; nMis = 0; checking = 1'b0; cyc = 0;

    // Basic round; LED activity during playback and a held value afterwards are ignored.
    clearStim(290);
    setLeds(0, 49, 4'b0001);
    setLeds(100, 149, 4'b0010);
    setLeds(255, 260, 4'b0100);
    setLeds(276, 289, 4'b0100);
    pin(0, 0, 0); pin(0, 3, 0); pin(0, 4, 0); pin(0, 2, 0);
    pin(249, 0, 0); pin(250, 0, 1); pin(257, 0, 1); pin(258, 0, 0);
    pin(266, 0, 2); pin(281, 4, 2); pin(281, 1, 0); pin(282, 1, 1);
    pin(282, 3, 0); pin(285, 3, 0);
    doReset();
    runScenario();

    // Back-to-back values without a dark gap.
    clearStim(180);
    setLeds(0, 19, 4'b0100);
    setLeds(20, 39, 4'b1000);
    pin(139, 4, 2); pin(140, 0, 4); pin(156, 0, 8); pin(172, 1, 1);
    doReset();
    runScenario();

    // Overflow with 17 displays, then a new round clears the flag.
    clearStim(535);
    for (int unsigned i = 0; i < 17; i++) setLeds(3*i, 3*i + 1, 4'(1 << (i % 4)));
    setLeds(410, 412, 4'b0001);
    pin(48, 2, 0); pin(49, 2, 1); pin(49, 4, 16); pin(150, 0, 1);
    pin(390, 0, 8); pin(406, 1, 1); pin(410, 2, 1); pin(411, 2, 0);
    pin(411, 4, 1); pin(513, 0, 1);
    doReset();
    runScenario();

    // Error injection at index 1; a 99-cycle dark gap does not end observation.
    erro_en  = 1'b1;
    erro_idx = 4'd1;
    clearStim(250);
    setLeds(0, 4, 4'b0001);
    setLeds(104, 108, 4'b1000);
    pin(208, 3, 1); pin(208, 4, 2); pin(209, 3, 2); pin(209, 0, 1);
    pin(225, 0, 1); pin(241, 1, 1);
    doReset();
    runScenario();
    erro_en  = 1'b0;
    erro_idx = 4'd0;

    // Abort in the third JOGA_ON cycle.
    clearStim(270);
    setLeds(0, 49, 4'b0001);
    setLeds(100, 149, 4'b0010);
    setHab(252, 259, 1'b0);
    pin(252, 3, 2); pin(252, 0, 1); pin(253, 0, 0); pin(253, 3, 0); pin(253, 4, 0);
    doReset();
    runScenario();

    // Reset pulled during OBSERVA with five values stored.
    seq5[0] = 4'b0001; seq5[1] = 4'b0010; seq5[2] = 4'b0100;
    seq5[3] = 4'b1000; seq5[4] = 4'b0001;
    clearStim(25);
    for (int unsigned i = 0; i < 5; i++) setLeds(5*i, 5*i + 2, seq5[i]);
    pin(24, 4, 5); pin(24, 3, 1);
    doReset();
    runScenario();
    chk("pre_reset_contagem", 32'(db_contagem), 5);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_chaves",   32'(chaves),      0);
    chk("rst_jogando",  32'(jogando),     0);
    chk("rst_pronto",   32'(pronto),      0);
    chk("rst_overflow", 32'(overflow),    0);
    chk("rst_estado",   32'(db_estado),   0);
    chk("rst_contagem", 32'(db_contagem), 0);

    // Fresh round replays only the new values.
    clearStim(150);
    setLeds(0, 3, 4'b1000);
    setLeds(6, 9, 4'b0100);
    pin(110, 0, 8); pin(126, 0, 4); pin(141, 4, 2); pin(142, 1, 1); pin(143, 3, 0);
    doReset();
    runScenario();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/jogador_automatico.md
# jogador_automatico

Automatic player for the memory game. Sits on the opposite side of the game datapath's LED/switch interface. It watches the `leds` bus while the game plays back a sequence, stores each displayed value, and once the display has been silent long enough it replays the stored values on `chaves` as timed key presses. Used for self-play on the board and as the stimulus engine in system-level benches. It can also inject a deliberate wrong press so the game's error path can be exercised.

## Interface
- `DEPTH`, 16: maximum sequence length stored.
- `QUIET`, 100: consecutive cycles with `leds == 0` that end observation.
- `HOLD`, 8: cycles each press is held on `chaves`.
- `GAP`, 8: cycles `chaves` is held at 0 between presses.

- `clock`, in, 1: single clock; all state is on its rising edge.
- `reset`, in, 1: asynchronous, active-low; clears all state.
- `habilita`, in, 1: level enable; 0 forces IDLE.
- `leds`, in, 4: game LED bus; one-hot value while shown, 0000 while off.
- `erro_en`, in, 1: enables error injection.
- `erro_idx`, in, 4: playback index that receives the wrong value.
- `chaves`, out, 4: registered key-press output to the game.
- `jogando`, out, 1: high in JOGA_ON and JOGA_OFF.
- `pronto`, out, 1: one-cycle pulse when playback of a round completes.
- `overflow`, out, 1: sticky; set when a capture is attempted while the count equals `DEPTH`.
- `db_estado`, out, 4: current state encoding.
- `db_contagem`, out, 5: number of stored values (0..16).

## Operation
- **States:** IDLE, OBSERVA, JOGA_ON, JOGA_OFF.
- **Edge condition:** `leds_prev` is a register of `leds`. A new display is `leds != 0` and `leds != leds_prev`.
- **IDLE:**
  - Outputs: `chaves = 0`, count = 0.
  - On a new display with `habilita = 1`: write `buf[0] = leds`, set count = 1, go to OBSERVA.
- **OBSERVA:**
  - On each new display: write `buf[count] = leds`, then increment count.
  - If count == `DEPTH` at capture: no write, set `overflow`.
  - Silence counter increments while `leds == 0` and clears when `leds != 0`.
  - When it reaches `QUIET`: clear idx, go to JOGA_ON.
- **JOGA_ON:**
  - `chaves = buf[idx]`.
  - If `erro_en` and `idx == erro_idx`, output the value rotated left by 1 instead (0001 becomes 0010; 1000 becomes 0001).
  - After `HOLD` cycles, go to JOGA_OFF.
- **JOGA_OFF:**
  - `chaves = 0` for `GAP` cycles, then increment idx.
  - If idx == count: pulse `pronto`, go to IDLE.
  - Otherwise go to JOGA_ON.
- **During playback:** `leds` is ignored in JOGA_ON and JOGA_OFF, and `leds_prev` keeps tracking.
- **`habilita` low:** from any state, synchronously go to IDLE. `chaves` is 0 on the next edge. `overflow` is kept.
- **`overflow` clear:** only by `reset`, or by the IDLE to OBSERVA transition.
- **Per-round behaviour:** every round restarts capture at index 0, because the game replays the full sequence each round.

## Timing
- **Reset values:** state IDLE, `chaves = 0000`, `jogando = 0`, `pronto = 0`, `overflow = 0`, count 0, idx 0, silence and hold timers 0.
- **Capture:** `leds` sampled in cycle t is written to the buffer at the edge ending cycle t. `db_contagem` reflects it in cycle t+1.
- **End of observation:** the first JOGA_ON cycle is exactly `QUIET` cycles after the first `leds == 0` cycle of the final silence.
- **Presses:** each press occupies exactly `HOLD` cycles, each gap exactly `GAP` cycles. No bubbles between phases.
- **`pronto`:** asserted in the single cycle after the last GAP cycle; state is IDLE in that same cycle.
- **Constraint:** `HOLD + GAP` must be less than the game's response timeout. `QUIET` must exceed the game's LED off-time.
- **Simultaneous events:** if `habilita` falls on the same edge as a capture or a phase end, `habilita` wins. No write, no `pronto`.
- **Counter widths:**
  - count is 5 bits.
  - idx is 4 bits.
  - Timers are `$clog2(max(QUIET, HOLD, GAP) + 1)` bits and saturate; they never wrap.

## Structure
- **Shared package:** state encoding (IDLE=0, OBSERVA=1, JOGA_ON=2, JOGA_OFF=3) and default `DEPTH`/`QUIET`/`HOLD`/`GAP` constants. The game top and benches use the same package.
- **Sub-module `buffer_sequencia`:** `DEPTH`x4 register file with synchronous write, asynchronous read, and write enable. It is cleared by `reset`.
- **Top level:** FSM, timers, `leds_prev` register and output register.

## Test plan
- **Basic round:** `leds` 0001 for 50 cycles, 0000 for 50, 0010 for 50, then 0000 → after 100 silent cycles, `chaves` goes 0001×8, 0000×8, 0010×8, 0000×8, then `pronto` pulses once, `db_contagem` = 2.
- **Back-to-back values:** `leds` changes 0100 → 1000 directly with no 0 between → both captured, playback 0100 then 1000.
- **Overflow:** 17 displays → `overflow` = 1, `db_contagem` = 16, playback of 16 values.
- **Error injection:** `erro_en` = 1, `erro_idx` = 1, stored sequence 0001, 1000 → playback 0001 then 0001 (1000 rotated left).
- **Abort:** `habilita` dropped in the 3rd cycle of JOGA_ON → `chaves` = 0 on the next edge, state IDLE, no `pronto`.
- **Reset mid-operation:** `reset` pulled low during OBSERVA with count 5 → all outputs at reset values immediately. A fresh round after release replays only the new values.
